// File: rtl/bcd_converter_pkg.sv
// Shared constants, register map, FSM state type and BCD digit helper for the
// binary-to-BCD AHB-Lite accelerator.
package bcd_converter_pkg;

   localparam int BIN_WIDTH   = 17;
   localparam int INT_DIGITS  = 3;
   localparam int FRAC_DIGITS = 2;
   localparam int FRAC_W      = 4 * FRAC_DIGITS;
   localparam int INT_W       = 4 * INT_DIGITS;
   localparam int BCD_DIGITS  = INT_DIGITS + FRAC_DIGITS;
   localparam int BCD_W       = 4 * BCD_DIGITS;

   localparam logic [31:0] MAX_VALUE = 32'd99999;

   localparam logic [1:0] ADDR_BIN  = 2'd0;
   localparam logic [1:0] ADDR_FRAC = 2'd1;
   localparam logic [1:0] ADDR_INT  = 2'd2;
   localparam logic [1:0] ADDR_STAT = 2'd3;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;

   localparam int STAT_BUSY = 0;
   localparam int STAT_OVF  = 1;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_e;

   function automatic logic [3:0] add3(input logic [3:0] digit);
      return (digit >= 4'd5) ? (digit + 4'd3) : digit;
   endfunction

endpackage

// File: rtl/bcd_converter_dd_core.sv
// Iterative double-dabble engine: one add-3/shift step per clock. A start
// request always (re)loads, so it doubles as abort for a running conversion.
module double_dabble_core
   import bcd_converter_pkg::*;
#(
   parameter int WIDTH  = 17,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   bin_q, bin_d;
   logic [ACC_W-1:0]   bcd_q, bcd_d;
   logic [ACC_W-1:0]   bcd_adj_s;
   logic [ACC_W-1:0]   bcd_shift_s;

   // One double-dabble step on the current accumulator.
   always_comb begin
      bcd_adj_s = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         bcd_adj_s[4*i +: 4] = add3(bcd_q[4*i +: 4]);
      end
      bcd_shift_s = {bcd_adj_s[ACC_W-2:0], bin_q[WIDTH-1]};
   end

   // Next-state and datapath control; done fires on the step that consumes the last bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      done_o  = 1'b0;
      if (start_i) begin
         state_d = CONVERT;
         cnt_d   = CNT_LOAD;
         bin_d   = bin_i;
         bcd_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            CONVERT: begin
               bcd_d = bcd_shift_s;
               bin_d = {bin_q[WIDTH-2:0], 1'b0};
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = IDLE;
                  done_o  = 1'b1;
               end else begin
                  state_d = CONVERT;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Engine state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
      end
   end

   assign busy_o = (state_q == CONVERT);
   assign bcd_o  = bcd_shift_s;

endmodule

// File: rtl/bcd_converter.sv
// AHB-Lite slave wrapper: register map, bus decode and read stall around the
// double-dabble core that turns a binary display value into packed BCD.
module bcd_converter
   import bcd_converter_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic        HSEL,
   input  logic [2:0]  HSIZE,
   input  logic [1:0]  HTRANS,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT
);

   localparam logic [BIN_WIDTH-1:0] MAX_BIN = MAX_VALUE[BIN_WIDTH-1:0];

   logic                 write_q, write_d;
   logic                 read_q, read_d;
   logic [1:0]           addr_q, addr_d;
   logic [BIN_WIDTH-1:0] bin_q, bin_d;
   logic [FRAC_W-1:0]    frac_q, frac_d;
   logic [INT_W-1:0]     int_q, int_d;
   logic                 ovf_q, ovf_d;
   logic                 start_s;
   logic                 busy_s;
   logic                 done_s;
   logic                 too_big_s;
   logic [BIN_WIDTH-1:0] src_s;
   logic [BCD_W-1:0]     bcd_s;
   logic [31:0]          status_s;
   logic                 unused_s;

   assign unused_s  = ^{HSIZE, HADDR[31:4], HADDR[1:0]};
   assign start_s   = write_q && (addr_q == ADDR_BIN);
   assign too_big_s = (HWDATA > MAX_VALUE);
   assign src_s     = too_big_s ? MAX_BIN : HWDATA[BIN_WIDTH-1:0];

   // Address-phase capture; a low HREADY means our own data phase is stalled, so hold.
   always_comb begin
      write_d = write_q;
      read_d  = read_q;
      addr_d  = addr_q;
      if (HREADY) begin
         if (HSEL && (HTRANS != HTRANS_IDLE)) begin
            write_d = HWRITE;
            read_d  = !HWRITE;
            addr_d  = HADDR[3:2];
         end else begin
            write_d = 1'b0;
            read_d  = 1'b0;
            addr_d  = ADDR_BIN;
         end
      end else begin
         write_d = write_q;
         read_d  = read_q;
         addr_d  = addr_q;
      end
   end

   // Register file: a new write beats a coincident commit of the old run.
   always_comb begin
      bin_d  = bin_q;
      ovf_d  = ovf_q;
      frac_d = frac_q;
      int_d  = int_q;
      if (start_s) begin
         bin_d = HWDATA[BIN_WIDTH-1:0];
         ovf_d = too_big_s;
      end else if (done_s) begin
         frac_d = bcd_s[FRAC_W-1:0];
         int_d  = bcd_s[FRAC_W +: INT_W];
      end else begin
         bin_d = bin_q;
      end
   end

   // Read mux, combinational from the captured address.
   always_comb begin
      status_s            = 32'h0000_0000;
      status_s[STAT_BUSY] = busy_s;
      status_s[STAT_OVF]  = ovf_q;
      HRDATA              = 32'h0000_0000;
      if (read_q) begin
         case (addr_q)
            ADDR_BIN:  HRDATA = 32'(bin_q);
            ADDR_FRAC: HRDATA = 32'(frac_q);
            ADDR_INT:  HRDATA = 32'(int_q);
            ADDR_STAT: HRDATA = status_s;
            default:   HRDATA = 32'h0000_0000;
         endcase
      end else begin
         HRDATA = 32'h0000_0000;
      end
   end

   assign HREADYOUT = !(read_q && busy_s &&
                        ((addr_q == ADDR_FRAC) || (addr_q == ADDR_INT)));

   // Bus-phase and result registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         write_q <= 1'b0;
         read_q  <= 1'b0;
         addr_q  <= ADDR_BIN;
         bin_q   <= '0;
         frac_q  <= '0;
         int_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         write_q <= write_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
         bin_q   <= bin_d;
         frac_q  <= frac_d;
         int_q   <= int_d;
         ovf_q   <= ovf_d;
      end
   end

   double_dabble_core #(
      .WIDTH  (BIN_WIDTH),
      .DIGITS (BCD_DIGITS)
   ) u_core (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .start_i (start_s),
      .bin_i   (src_s),
      .busy_o  (busy_s),
      .done_o  (done_s),
      .bcd_o   (bcd_s)
   );

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: the driver pushes expected read data and
// wait-state counts computed from a decimal reference model; a monitor checks them.
module tb_bcd_converter;

   localparam int          LAT  = 17;
   localparam logic [31:0] MAXV = 32'd99999;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic        HREADY;
   logic        HSEL;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HRDATA;
   logic        HREADYOUT;

   assign HREADY = HREADYOUT;

   bcd_converter dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HSEL      (HSEL),
      .HSIZE     (HSIZE),
      .HTRANS    (HTRANS),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [1:0]  a;
      logic [31:0] exp;
      int          stalls;
      int          d;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          done_req = 1'b0;
   bit          mon_done = 1'b0;

   // reference model state
   logic [31:0] m_bin = 32'd0;
   logic        m_ovf = 1'b0;
   logic [31:0] m_frac = 32'd0;
   logic [31:0] m_int = 32'd0;
   int          m_tw = 0;
   bit          m_have = 1'b0;

   always @(posedge HCLK) cyc++;

   function automatic logic [31:0] to_bcd(input int unsigned x, input int nd);
      logic [31:0] r;
      int unsigned y;
      r = 32'd0;
      y = x;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(y % 10);
         y = y / 10;
      end
      return r;
   endfunction

   function automatic bit m_busy(input int d);
      return m_have && (d > m_tw) && (d <= m_tw + LAT);
   endfunction

   function automatic int m_stalls(input int d);
      return m_busy(d) ? (m_tw + LAT + 1 - d) : 0;
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge HCLK);
      while (!HREADYOUT) begin
         n++;
         if (n > 100) begin
            $display("FAIL hready_timeout: HREADYOUT=%0b want 1 within 100 cycles", HREADYOUT);
            $fatal(1, "bus wait bound expired");
         end
         @(negedge HCLK);
      end
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge HCLK);
         #1;
      end
   endtask

   task automatic addr_phase(input bit w, input logic [3:0] a);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = {28'h0, a};
      HWRITE = w;
      wait_ready();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
   endtask

   task automatic wr_to(input logic [3:0] a, input logic [31:0] wd);
      logic [31:0] v;
      addr_phase(1'b1, a);
      HWDATA = wd;
      if (a[3:2] == 2'd0) begin
         v      = (wd > MAXV) ? MAXV : wd;
         m_bin  = wd & 32'h0001_FFFF;
         m_ovf  = (wd > MAXV);
         m_frac = to_bcd(v % 100, 2);
         m_int  = to_bcd(v / 100, 3);
         m_tw   = cyc;
         m_have = 1'b1;
      end
   endtask

   task automatic wr(input logic [31:0] wd);
      wr_to(4'h0, wd);
   endtask

   task automatic rd(input logic [3:0] a);
      exp_t e;
      addr_phase(1'b0, a);
      e.a      = a[3:2];
      e.d      = cyc;
      e.stalls = 0;
      case (a[3:2])
         2'd0:    e.exp = m_bin;
         2'd1:    begin e.exp = m_frac; e.stalls = m_stalls(cyc); end
         2'd2:    begin e.exp = m_int;  e.stalls = m_stalls(cyc); end
         default: e.exp = {30'd0, m_ovf, m_busy(cyc)};
      endcase
      sb_q.push_back(e);
   endtask

   task automatic rd_exp(input logic [3:0] a, input logic [31:0] x, input int st);
      exp_t e;
      addr_phase(1'b0, a);
      e.a      = a[3:2];
      e.d      = cyc;
      e.exp    = x;
      e.stalls = st;
      sb_q.push_back(e);
   endtask

   // Monitor: tracks read data phases on the bus and checks them against the scoreboard.
   always @(negedge HCLK) begin : mon
      static bit rd_active = 1'b0;
      static int stall_cnt = 0;
      exp_t e;
      if (rd_active) begin
         if (!HREADYOUT) begin
            stall_cnt++;
         end else begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL sb_empty: got read data %h with no expectation queued", HRDATA);
            end else begin
               e = sb_q.pop_front();
               if (HRDATA !== e.exp) begin
                  bad++;
                  $display("FAIL rd_0x%0h: got %h want %h (dphase cycle %0d)",
                           {e.a, 2'b00}, HRDATA, e.exp, e.d);
               end
               total++;
               if (stall_cnt != e.stalls) begin
                  bad++;
                  $display("FAIL wait_0x%0h: got %0d wait states want %0d (dphase cycle %0d)",
                           {e.a, 2'b00}, stall_cnt, e.stalls, e.d);
               end
            end
            stall_cnt = 0;
         end
      end
      if (!HRESETn) rd_active = 1'b0;
      else if (HREADYOUT) rd_active = HSEL && (HTRANS != 2'b00) && !HWRITE;
      if (done_req && !mon_done) begin
         total++;
         if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d unchecked reads want 0", sb_q.size());
         end
         mon_done = 1'b1;
      end
   end

   initial begin
      int unsigned v;
      int unsigned sel;
      HRESETn = 1'b0;
      HADDR   = 32'h0;
      HWDATA  = 32'h0;
      HWRITE  = 1'b0;
      HSEL    = 1'b0;
      HSIZE   = 3'b010;
      HTRANS  = 2'b00;
      idle(3);
      HRESETn = 1'b1;
      idle(1);

      // reset state
      rd(4'h4); rd(4'h8); rd(4'hC); rd(4'h0);

      // nominal conversion with status streamed every cycle
      wr(32'd12345);
      repeat (20) rd(4'hC);
      rd(4'h4); rd(4'h8); rd(4'hC);

      // maximum value, read issued right after the write completes
      wr(32'd99999);
      wait_ready();
      rd(4'h8); rd(4'h4);

      // saturation and readback truncation
      wr(32'd100000);
      rd(4'hC);
      idle(18);
      rd(4'h4); rd(4'h8); rd(4'hC); rd(4'h0);
      wr(32'h0002_0005);
      rd(4'h0); rd(4'h8); rd(4'hC);
      wr(32'hFFFF_FFFF);
      rd(4'h0); rd(4'h4);

      // zero
      wr(32'd0);
      rd(4'h4); rd(4'h8); rd(4'hC);

      // abort at busy cycle 8
      wr(32'd5);
      idle(7);
      wr(32'd250);
      repeat (20) rd(4'hC);
      rd(4'h4); rd(4'h8);

      // write data phase on the final convert edge
      wr(32'd7);
      idle(16);
      wr(32'd88);
      rd(4'h4); rd(4'h8); rd(4'hC);

      // writes to read-only registers are ignored
      wr_to(4'h8, 32'h0000_0777);
      wr_to(4'hC, 32'hFFFF_FFFF);
      wr_to(4'h4, 32'h0000_0011);
      rd(4'h8); rd(4'hC); rd(4'h4);

      // randomized values and gaps
      for (int k = 0; k < 14; k++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       v = $urandom();
            1:       v = $urandom_range(0, 999);
            default: v = $urandom_range(0, 99999);
         endcase
         wr(v);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20));
         rd(4'hC); rd(4'h4); rd(4'h8); rd(4'h0); rd(4'hC);
      end

      // reset during a stalled integer read at busy cycle 9
      wr(32'd777);
      rd_exp(4'h8, 32'h0, 8);
      idle(8);
      HRESETn = 1'b0;
      m_bin  = 32'd0;
      m_ovf  = 1'b0;
      m_frac = 32'd0;
      m_int  = 32'd0;
      m_have = 1'b0;
      idle(2);
      HRESETn = 1'b1;
      idle(1);
      rd(4'hC); rd(4'h4); rd(4'h8);
      wr(32'd42);
      rd(4'h4); rd(4'h8); rd(4'hC);

      wait_ready();
      idle(2);
      done_req = 1'b1;
      repeat (3) @(negedge HCLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
